// File: rtl/seg_scan_display_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   - SEG_0..SEG_F, SEG_OFF : active-high abcdefg glyphs, bit 6 = a, bit 0 = g.
//   - clog2()               : counter width helper, elaboration-time only.
package seg_scan_display_pkg;

    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_A   = 7'b1110111;
    localparam logic [6:0] SEG_B   = 7'b0011111;
    localparam logic [6:0] SEG_C   = 7'b1001110;
    localparam logic [6:0] SEG_D   = 7'b0111101;
    localparam logic [6:0] SEG_E   = 7'b1001111;
    localparam logic [6:0] SEG_F   = 7'b1000111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Smallest w such that 2**w >= n; returns at least 1 so every counter
    // has a real bit even for degenerate parameter values.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Bus between the CPU debug-select mux and the display driver, plus the
// board-pin side of the driver.
//   master : drives enable/load/value/dp_mask/lz_suppress, observes pins.
//   slave  : the display driver itself.
// load is a single-cycle strobe with no back-pressure: the driver accepts
// value/dp_mask/lz_suppress in every cycle load is high, with or without
// enable.
interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_mask;
    logic                      lz_suppress;
    logic [6:0]                a_to_g;
    logic [NUM_DIGITS-1:0]     en;
    logic                      dp;
    logic                      frame_done;

    modport master (
        output enable, load, value, dp_mask, lz_suppress,
        input  a_to_g, en, dp, frame_done
    );

    modport slave (
        input  enable, load, value, dp_mask, lz_suppress,
        output a_to_g, en, dp, frame_done
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment glyph, active-high.
//   nibble : 4-bit value 0..F
//   seg    : abcdefg, seg[6] = a ... seg[0] = g
module seg7_hex_decode
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_OFF;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment display driver.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : slave side of seg_scan_display_if (controls in, pins out)
// A prescaler produces one tick every DIV enabled cycles; the digit index
// advances on each tick. A shadow copy of value/dp_mask/blank mask is taken
// on load. Pins are registered from index + shadow, so they lag one cycle.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    seg_scan_display_if.slave   bus
);
    localparam int CW = clog2(DIV);
    localparam int IW = clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    // Pin level meaning "off" for every output.
    localparam logic [6:0]            SEG_IDLE = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] EN_IDLE  = ACTIVE_LOW ? '1 : '0;
    localparam logic                  DP_IDLE  = ACTIVE_LOW;

    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   val_q, val_d;
    logic [NUM_DIGITS-1:0]     dpm_q, dpm_d;
    logic [NUM_DIGITS-1:0]     blank_q, blank_d;
    logic [6:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     en_q, en_d;
    logic                      dp_q, dp_d;
    logic                      fd_q, fd_d;

    logic                      tick;
    logic                      zero_run;
    logic [NUM_DIGITS-1:0]     blank_new;
    logic [3:0]                cur_nib;
    logic                      cur_blank;
    logic                      cur_dpm;
    logic [6:0]                glyph;

    seg7_hex_decode u_dec (
        .nibble (cur_nib),
        .seg    (glyph)
    );

    // Blank mask from the incoming value: walk down from the top digit while
    // every nibble seen so far is zero. Digit 0 is never part of the walk.
    always_comb begin
        zero_run  = 1'b1;
        blank_new = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run & (bus.value[4*k +: 4] == 4'd0);
            blank_new[k] = bus.lz_suppress & zero_run;
        end
    end

    // Fields of the digit currently addressed by the index.
    always_comb begin
        cur_nib   = 4'd0;
        cur_blank = 1'b0;
        cur_dpm   = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib   = val_q[4*k +: 4];
                cur_blank = blank_q[k];
                cur_dpm   = dpm_q[k];
            end
        end
    end

    always_comb begin
        tick = bus.enable && (cnt_q == CNT_MAX);

        cnt_d = cnt_q;
        idx_d = idx_q;
        if (bus.enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        val_d   = val_q;
        dpm_d   = dpm_q;
        blank_d = blank_q;
        if (bus.load) begin
            val_d   = bus.value;
            dpm_d   = bus.dp_mask;
            blank_d = blank_new;
        end

        fd_d  = tick && (idx_q == IDX_MAX);

        seg_d = SEG_IDLE;
        en_d  = EN_IDLE;
        dp_d  = DP_IDLE;
        if (bus.enable) begin
            en_d = '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                en_d[k] = (idx_q == IW'(k));
            end
            seg_d = cur_blank ? SEG_OFF : glyph;
            dp_d  = cur_dpm & ~cur_blank;
            if (ACTIVE_LOW) begin
                en_d  = ~en_d;
                seg_d = ~seg_d;
                dp_d  = ~dp_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            dpm_q   <= '0;
            blank_q <= '0;
            seg_q   <= SEG_IDLE;
            en_q    <= EN_IDLE;
            dp_q    <= DP_IDLE;
            fd_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            dpm_q   <= dpm_d;
            blank_q <= blank_d;
            seg_q   <= seg_d;
            en_q    <= en_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
        end
    end

    assign bus.a_to_g     = seg_q;
    assign bus.en         = en_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display with NUM_DIGITS=4, DIV=4, ACTIVE_LOW=1.
// Reference model: time-slot arithmetic (cycle count, digit = slot mod 4),
// glyph lookup table and leading-zero rule by shifting the snapshot value.
module tb_seg_scan_display;

    logic clk;
    logic reset;

    seg_scan_display_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_display #(
        .NUM_DIGITS (4),
        .DIV        (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fd_seen = 0;

    // Reference state
    int          m_cnt;
    int          m_idx;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_lz;
    logic [6:0]  glyph_tab [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_blank(input logic [15:0] v, input logic lz, input int k);
        return lz && (k > 0) && ((v >> (4 * k)) == 16'd0);
    endfunction

    // One clock: predict the pins, advance the model, clock the DUT, compare.
    task automatic step();
        logic [3:0] e_en;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fd;
        logic [3:0] nib;
        logic       blk;
        if (reset) begin
            e_en = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            m_cnt = 0; m_idx = 0; m_val = '0; m_dp = '0; m_lz = 1'b0;
        end else begin
            e_fd = bus.enable && (m_cnt == 3) && (m_idx == 3);
            if (bus.enable) begin
                nib   = 4'((m_val >> (4 * m_idx)) & 16'hF);
                blk   = is_blank(m_val, m_lz, m_idx);
                e_en  = ~(4'b0001 << m_idx);
                e_seg = blk ? 7'h7F : ~glyph_tab[nib];
                e_dp  = ~(m_dp[m_idx] && !blk);
            end else begin
                e_en = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            if (bus.load) begin
                m_val = bus.value;
                m_dp  = bus.dp_mask;
                m_lz  = bus.lz_suppress;
            end
            if (bus.enable) begin
                if (m_cnt == 3) begin
                    m_cnt = 0;
                    m_idx = (m_idx + 1) % 4;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("en", 32'(bus.en), 32'(e_en));
        chk("a_to_g", 32'(bus.a_to_g), 32'(e_seg));
        chk("dp", 32'(bus.dp), 32'(e_dp));
        chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
        if (bus.frame_done === 1'b1) fd_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_en(input logic [3:0] target, input int max_cycles);
        logic found;
        found = (bus.en === target);
        for (int i = 0; i < max_cycles && !found; i++) begin
            step();
            found = (bus.en === target);
        end
        chk("wait_en", 32'(found), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpm, input logic lz);
        bus.value       = v;
        bus.dp_mask     = dpm;
        bus.lz_suppress = lz;
        bus.load        = 1'b1;
        step();
        bus.load        = 1'b0;
    endtask

    initial begin
        logic [6:0] exp_g;
        int         k;
        int         guard;

        glyph_tab[0]  = 7'b1111110; glyph_tab[1]  = 7'b0110000;
        glyph_tab[2]  = 7'b1101101; glyph_tab[3]  = 7'b1111001;
        glyph_tab[4]  = 7'b0110011; glyph_tab[5]  = 7'b1011011;
        glyph_tab[6]  = 7'b1011111; glyph_tab[7]  = 7'b1110000;
        glyph_tab[8]  = 7'b1111111; glyph_tab[9]  = 7'b1111011;
        glyph_tab[10] = 7'b1110111; glyph_tab[11] = 7'b0011111;
        glyph_tab[12] = 7'b1001110; glyph_tab[13] = 7'b0111101;
        glyph_tab[14] = 7'b1001111; glyph_tab[15] = 7'b1000111;

        m_cnt = 0; m_idx = 0; m_val = '0; m_dp = '0; m_lz = 1'b0;
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.load        = 1'b0;
        bus.value       = '0;
        bus.dp_mask     = '0;
        bus.lz_suppress = 1'b0;

        // Reset held two cycles
        run(2);
        chk("reset_en", 32'(bus.en), 32'h0000_000F);
        chk("reset_seg", 32'(bus.a_to_g), 32'h0000_007F);
        reset = 1'b0;

        // Plain scan of 1234
        bus.enable = 1'b1;
        do_load(16'h1234, 4'b0000, 1'b0);
        fd_seen = 0;
        run(32);
        chk("frame_count", 32'(fd_seen), 32'd2);
        wait_en(4'b1110, 20);
        chk("digit0_glyph4", 32'(bus.a_to_g), 32'(7'b1001100));

        // Leading zero blanking
        do_load(16'h0050, 4'b0000, 1'b1);
        wait_en(4'b1101, 20);
        chk("lz_digit1_5", 32'(bus.a_to_g), 32'(7'b0100100));
        wait_en(4'b1110, 20);
        chk("lz_digit0_0", 32'(bus.a_to_g), 32'(7'b0000001));
        wait_en(4'b0111, 20);
        chk("lz_digit3_off", 32'(bus.a_to_g), 32'h0000_007F);
        do_load(16'h0000, 4'b0000, 1'b1);
        wait_en(4'b1110, 20);
        chk("zero_digit0_lit", 32'(bus.a_to_g), 32'(7'b0000001));
        wait_en(4'b1101, 20);
        chk("zero_digit1_off", 32'(bus.a_to_g), 32'h0000_007F);

        // dp against blanking
        do_load(16'h0007, 4'b1111, 1'b1);
        wait_en(4'b1110, 20);
        chk("dp_digit0_on", 32'(bus.dp), 32'd0);
        wait_en(4'b1101, 20);
        chk("dp_digit1_blank", 32'(bus.dp), 32'd1);

        // Pause mid-slot on digit 2, then resume
        do_load(16'h9876, 4'b0100, 1'b0);
        wait_en(4'b1011, 20);
        step();
        bus.enable = 1'b0;
        step();
        chk("pause_en_off", 32'(bus.en), 32'h0000_000F);
        run(5);
        bus.enable = 1'b1;
        run(10);

        // Load coincident with a tick
        guard = 0;
        while (m_cnt != 3 && guard < 8) begin
            step();
            guard++;
        end
        chk("reach_tick", 32'(m_cnt), 32'd3);
        do_load(16'hABCD, 4'b0000, 1'b0);
        k = m_idx;
        exp_g = ~glyph_tab[4'((16'hABCD >> (4 * k)) & 16'hF)];
        step();
        chk("tick_load_glyph", 32'(bus.a_to_g), 32'(exp_g));
        run(8);

        // Reset mid-frame
        reset = 1'b1;
        step();
        chk("midreset_fd", 32'(bus.frame_done), 32'd0);
        chk("midreset_en", 32'(bus.en), 32'h0000_000F);
        reset = 1'b0;
        run(20);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            reset           = ($urandom_range(0, 149) == 0);
            bus.enable      = ($urandom_range(0, 9) != 0);
            bus.load        = ($urandom_range(0, 7) == 0);
            bus.value       = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
            bus.dp_mask     = 4'($urandom_range(0, 15));
            bus.lz_suppress = 1'($urandom_range(0, 1));
            step();
        end
        reset    = 1'b0;
        bus.load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
